// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared opcode and state encodings for the multiply/divide unit
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - unsigned accumulator with one shift-add or restoring shift-subtract step per cycle
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     init_lo,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   result
);

    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_next;
    logic [2*WIDTH:0] div_shift;
    logic [WIDTH:0]   div_upper;
    logic [2*WIDTH:0] div_next;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    // Divide: shift left, then subtract the divisor if it fits and shift in a quotient one.
    always_comb begin
        mul_sum   = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
        mul_next  = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:0], 1'b0};
        div_upper = div_shift[2*WIDTH:WIDTH];
        div_next  = div_shift;
        if (div_upper >= {1'b0, opnd})
            div_next = {div_upper - {1'b0, opnd}, div_shift[WIDTH-1:1], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{(WIDTH+1){1'b0}}, init_lo};
            opnd     <= operand;
            div_mode <= is_div;
        end else if (step) begin
            acc      <= div_mode ? div_next : mul_next;
        end
    end

    assign result = acc[2*WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             MDStartE,
    input  logic [2:0]       MDOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             MDBusyE,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut,
    output logic             MDDoneE
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             is_div_q;
    logic             sign_q;
    logic             rem_sign_q;
    logic             dz_q;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             start_op;
    logic             signed_in;
    logic             is_div_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] result;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Opcodes 0xx are the four iterative ops; bit 0 selects unsigned, bit 1 selects divide.
    always_comb begin
        start_op  = (state == S_IDLE) && MDStartE && !MDOpE[2];
        signed_in = !MDOpE[0];
        is_div_in = MDOpE[1];
        a_mag     = (signed_in && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        b_mag     = (signed_in && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        prod_fix  = sign_q ? -result : result;
        quo_fix   = sign_q ? -result[WIDTH-1:0] : result[WIDTH-1:0];
        rem_fix   = rem_sign_q ? -result[2*WIDTH-1:WIDTH] : result[2*WIDTH-1:WIDTH];
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (RST),
        .load    (start_op),
        .step    (state == S_RUN),
        .is_div  (is_div_in),
        .init_lo (is_div_in ? a_mag : b_mag),
        .operand (is_div_in ? b_mag : a_mag),
        .result  (result)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_div_q   <= 1'b0;
            sign_q     <= 1'b0;
            rem_sign_q <= 1'b0;
            dz_q       <= 1'b0;
            a_orig     <= '0;
            hi         <= '0;
            lo         <= '0;
            MDBusyE    <= 1'b0;
            MDDoneE    <= 1'b0;
        end else begin
            MDDoneE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MDStartE) begin
                        case (md_op_e'(MDOpE))
                            MD_MTHI: hi <= SrcAE;
                            MD_MTLO: lo <= SrcAE;
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                is_div_q   <= is_div_in;
                                sign_q     <= signed_in && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                                rem_sign_q <= signed_in && SrcAE[WIDTH-1];
                                dz_q       <= (SrcBE == '0);
                                a_orig     <= SrcAE;
                                cnt        <= '0;
                                state      <= S_RUN;
                                MDBusyE    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi <= a_orig;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    state   <= S_IDLE;
                    MDBusyE <= 1'b0;
                    MDDoneE <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign HIOut = hi;
    assign LOOut = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        MDStartE = 1'b0;
    logic [2:0]  MDOpE = 3'b000;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        MDBusyE;
    logic [31:0] HIOut;
    logic [31:0] LOOut;
    logic        MDDoneE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .RST      (RST),
        .MDStartE (MDStartE),
        .MDOpE    (MDOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .MDBusyE  (MDBusyE),
        .HIOut    (HIOut),
        .LOOut    (LOOut),
        .MDDoneE  (MDDoneE)
    );

    // Issues one op and follows it until one cycle after busy falls.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_pulses,
                          output logic done_at_fall, output logic leak);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = HIOut; lo0 = LOOut;
        MDOpE = op; SrcAE = a; SrcBE = b; MDStartE = 1'b1;
        @(negedge clk);
        MDStartE = 1'b0;
        busy_cycles = 0; done_pulses = 0; leak = 1'b0;
        while (MDBusyE && busy_cycles < 100) begin
            busy_cycles++;
            if (MDDoneE) done_pulses++;
            if (HIOut !== hi0 || LOOut !== lo0) leak = 1'b1;
            @(negedge clk);
        end
        done_at_fall = MDDoneE;
        if (MDDoneE) done_pulses++;
        @(negedge clk);
        if (MDDoneE) done_pulses++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({MDBusyE, MDDoneE, HIOut, LOOut} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", MDBusyE, MDDoneE, HIOut, LOOut);
        end
        RST = 1'b0;
        @(negedge clk);
        checks++;
        if ({MDBusyE, MDDoneE, HIOut, LOOut} !== 66'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h, required all zero", MDBusyE, MDDoneE, HIOut, LOOut);
        end
    endtask

    task automatic test_mult();
        int bc, dp; logic df, lk;
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, bc, dp, df, lk);
        checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d required 33", bc); end
        checks++; if (df !== 1'b1 || dp !== 1) begin errors++; $display("FAIL mult_done_pulse: at_fall=%b pulses=%0d required 1/1", df, dp); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL mult_hilo_hold: intermediate HI/LO change seen"); end
        checks++; if (HIOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h required ffffffff", HIOut); end
        checks++; if (LOOut !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h required ffffffeb", LOOut); end
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, bc, dp, df, lk);
        checks++; if (HIOut !== 32'h4000_0000 || LOOut !== 32'h0) begin errors++; $display("FAIL mult_minint_sq: got %h_%h required 40000000_00000000", HIOut, LOOut); end
    endtask

    task automatic test_multu_div();
        int bc, dp; logic df, lk;
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dp, df, lk);
        checks++; if (HIOut !== 32'hFFFF_FFFE || LOOut !== 32'h0000_0001) begin errors++; $display("FAIL multu_max: got %h_%h required fffffffe_00000001", HIOut, LOOut); end
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, bc, dp, df, lk);
        checks++; if (bc !== 33) begin errors++; $display("FAIL div_busy_cycles: got %0d required 33", bc); end
        checks++; if (LOOut !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_quot: got %h required fffffffd", LOOut); end
        checks++; if (HIOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_rem: got %h required ffffffff", HIOut); end
        run_op(3'b011, 32'd100, 32'd7, bc, dp, df, lk);
        checks++; if (HIOut !== 32'd2 || LOOut !== 32'd14) begin errors++; $display("FAIL divu_100_7: got hi=%h lo=%h required hi=2 lo=e", HIOut, LOOut); end
    endtask

    task automatic test_divzero_overflow();
        int bc, dp; logic df, lk;
        run_op(3'b011, 32'd100, 32'd0, bc, dp, df, lk);
        checks++; if (bc !== 33) begin errors++; $display("FAIL divzero_busy_cycles: got %0d required 33", bc); end
        checks++; if (LOOut !== 32'hFFFF_FFFF || HIOut !== 32'h0000_0064) begin errors++; $display("FAIL divzero_result: got hi=%h lo=%h required hi=64 lo=ffffffff", HIOut, LOOut); end
        run_op(3'b010, 32'hFFFF_FF9C, 32'd0, bc, dp, df, lk);
        checks++; if (LOOut !== 32'hFFFF_FFFF || HIOut !== 32'hFFFF_FF9C) begin errors++; $display("FAIL div_signed_zero: got hi=%h lo=%h required hi=ffffff9c lo=ffffffff", HIOut, LOOut); end
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, bc, dp, df, lk);
        checks++; if (LOOut !== 32'h8000_0000 || HIOut !== 32'h0) begin errors++; $display("FAIL div_overflow: got hi=%h lo=%h required hi=0 lo=80000000", HIOut, LOOut); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        MDOpE = 3'b100; SrcAE = 32'h1234_5678; MDStartE = 1'b1;
        @(negedge clk);
        checks++; if (HIOut !== 32'h1234_5678 || MDBusyE !== 1'b0) begin errors++; $display("FAIL mthi: got hi=%h busy=%b required 12345678/0", HIOut, MDBusyE); end
        MDOpE = 3'b101; SrcAE = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (LOOut !== 32'hCAFE_F00D || HIOut !== 32'h1234_5678 || MDBusyE !== 1'b0) begin errors++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b required 12345678/cafef00d/0", HIOut, LOOut, MDBusyE); end
        MDOpE = 3'b110; SrcAE = 32'hDEAD_BEEF;
        @(negedge clk);
        MDStartE = 1'b0;
        checks++; if (HIOut !== 32'h1234_5678 || LOOut !== 32'hCAFE_F00D || MDBusyE !== 1'b0 || MDDoneE !== 1'b0) begin errors++; $display("FAIL reserved_op: got hi=%h lo=%h busy=%b done=%b required no change", HIOut, LOOut, MDBusyE, MDDoneE); end
        @(negedge clk);
        checks++; if (MDBusyE !== 1'b0 || MDDoneE !== 1'b0) begin errors++; $display("FAIL move_no_busy: busy=%b done=%b required 0/0", MDBusyE, MDDoneE); end
    endtask

    task automatic test_start_while_busy();
        int bc; int extra_busy;
        @(negedge clk);
        MDOpE = 3'b000; SrcAE = 32'd5; SrcBE = 32'd6; MDStartE = 1'b1;
        @(negedge clk);
        MDStartE = 1'b0;
        repeat (9) @(negedge clk);
        MDOpE = 3'b011; SrcAE = 32'd9; SrcBE = 32'd3; MDStartE = 1'b1;
        bc = 10;
        @(negedge clk);
        MDStartE = 1'b0;
        while (MDBusyE && bc < 100) begin bc++; @(negedge clk); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL ignore_busy_cycles: got %0d required 33", bc); end
        checks++; if (HIOut !== 32'd0 || LOOut !== 32'd30) begin errors++; $display("FAIL ignore_result: got hi=%h lo=%h required hi=0 lo=1e", HIOut, LOOut); end
        extra_busy = 0;
        repeat (40) begin @(negedge clk); if (MDBusyE) extra_busy++; end
        checks++; if (extra_busy !== 0) begin errors++; $display("FAIL ignore_no_second_op: busy cycles after done=%0d required 0", extra_busy); end
    endtask

    task automatic test_reset_abort();
        int late;
        @(negedge clk);
        MDOpE = 3'b000; SrcAE = 32'h0000_1234; SrcBE = 32'h10; MDStartE = 1'b1;
        @(negedge clk);
        MDStartE = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (MDBusyE !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b required 1", MDBusyE); end
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        checks++; if ({MDBusyE, MDDoneE, HIOut, LOOut} !== 66'd0) begin errors++; $display("FAIL abort_state: busy=%b done=%b hi=%h lo=%h required all zero", MDBusyE, MDDoneE, HIOut, LOOut); end
        late = 0;
        repeat (40) begin @(negedge clk); if (MDDoneE || MDBusyE || HIOut != 0 || LOOut != 0) late++; end
        checks++; if (late !== 0) begin errors++; $display("FAIL abort_quiet: activity cycles after abort=%0d required 0", late); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_div();
        test_divzero_overflow();
        test_mthi_mtlo();
        test_start_while_busy();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
